// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation stations: dispatch payload,
// per-slot entry, the scheduler-facing rs_out_t, and the CDB capture helper.
package reservation_station_pkg;

  localparam int RS_DEPTH  = 2;
  localparam int ROB_TAG_W = 4;

  typedef struct packed {
    logic                 ready;
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          value;
  } rs_src_t;

  typedef struct packed {
    logic [2:0]           ALU_op;
    logic [1:0]           branch_type;
    logic [ROB_TAG_W-1:0] ROB_entry;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_dispatch_t;

  typedef struct packed {
    logic                 valid;
    logic [2:0]           ALU_op;
    logic [1:0]           branch_type;
    logic [ROB_TAG_W-1:0] ROB_entry;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

  typedef struct packed {
    logic                 valid_operands;
    logic [2:0]           ALU_op;
    logic [ROB_TAG_W-1:0] ROB_entry;
    logic [1:0]           branch_type;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
  } rs_out_t;

  // A waiting source latches the broadcast value when the CDB carries its tag.
  function automatic rs_src_t capture(input rs_src_t src, input logic cdb_valid,
                                      input logic [ROB_TAG_W-1:0] cdb_tag,
                                      input logic [31:0] cdb_value);
    rs_src_t r;
    r = src;
    if (!src.ready && cdb_valid && (src.tag == cdb_tag)) begin
      r.ready = 1'b1;
      r.value = cdb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: valid bit, two sources with CDB snoop/capture.
// RS_WAKEUP_BYPASS_EN makes a slot eligible in the CDB broadcast cycle itself.
module rs_entry
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  rs_dispatch_t         alloc_data,
  input  logic                 clear,
  input  logic                 flush,
  input  logic                 cdb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  output rs_entry_t            entry,
  output logic                 eligible,
  output logic [31:0]          rs1,
  output logic [31:0]          rs2
);

  // NOTE: sequential state uses non-blocking assignments only, so every slot
  // samples the same pre-edge values regardless of process ordering.
  // NOTE: the whole slot is reset, not just valid, so the payload never
  // carries X into rs_data after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry <= '0;
    end else if (flush || clear) begin
      // A consume beats a CDB capture landing on the same slot.
      entry.valid <= 1'b0;
    end else if (alloc) begin
      entry <= '{valid:       1'b1,
                 ALU_op:      alloc_data.ALU_op,
                 branch_type: alloc_data.branch_type,
                 ROB_entry:   alloc_data.ROB_entry,
                 src1:        capture(alloc_data.src1, cdb_valid, cdb_tag, cdb_value),
                 src2:        capture(alloc_data.src2, cdb_valid, cdb_tag, cdb_value)};
    end else if (entry.valid) begin
      entry.src1 <= capture(entry.src1, cdb_valid, cdb_tag, cdb_value);
      entry.src2 <= capture(entry.src2, cdb_valid, cdb_tag, cdb_value);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  logic hit1, hit2;
  assign hit1     = cdb_valid && (entry.src1.tag == cdb_tag);
  assign hit2     = cdb_valid && (entry.src2.tag == cdb_tag);
  assign eligible = entry.valid && (entry.src1.ready || hit1) && (entry.src2.ready || hit2);
  assign rs1      = entry.src1.ready ? entry.src1.value : cdb_value;
  assign rs2      = entry.src2.ready ? entry.src2.value : cdb_value;
`else
  assign eligible = entry.valid && entry.src1.ready && entry.src2.ready;
  assign rs1      = entry.src1.value;
  assign rs2      = entry.src2.value;
`endif

endmodule

// File: rtl/reservation_station.sv
// Reservation station: allocation, lowest-index issue select, pick tracking for
// the valid_operands/consumed handshake, and occupancy. See RS_WAKEUP_BYPASS_EN in rs_entry.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dispatch_valid,
  input  rs_dispatch_t               dispatch_data,
  output logic                       dispatch_ready,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_value,
  input  logic                       consumed,
  input  logic                       flush,
  output rs_out_t                    rs_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  rs_entry_t        entries [DEPTH];
  logic [31:0]      rs1_vec [DEPTH];
  logic [31:0]      rs2_vec [DEPTH];
  logic [DEPTH-1:0] valid_vec, eligible_vec, alloc_vec, clear_vec;
  logic [IDX_W-1:0] free_idx, sel_idx, last_pick_idx;
  logic             sel_found, last_pick_valid;
  logic             dispatch_fire, consume_fire;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    rs_entry u_entry (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc_vec[i]),
      .alloc_data (dispatch_data),
      .clear      (clear_vec[i]),
      .flush      (flush),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .entry      (entries[i]),
      .eligible   (eligible_vec[i]),
      .rs1        (rs1_vec[i]),
      .rs2        (rs2_vec[i])
    );
    assign valid_vec[i] = entries[i].valid;
  end

  // Free-slot and issue pickers work from registered valid bits only, so a
  // slot freed by this cycle's consume is not reused until next cycle.
  assign dispatch_ready = ~&valid_vec;
  assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  assign consume_fire   = consumed && last_pick_valid && !flush;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
      if (eligible_vec[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    alloc_vec = '0;
    clear_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_vec[i] = dispatch_fire && (free_idx == IDX_W'(i));
      clear_vec[i] = consume_fire && (last_pick_idx == IDX_W'(i));
    end
  end

  // consumed only masks valid_operands; the payload still shows the pick.
  always_comb begin
    rs_data = '0;
    if (sel_found) begin
      rs_data.valid_operands = !consumed;
      rs_data.ALU_op         = entries[sel_idx].ALU_op;
      rs_data.ROB_entry      = entries[sel_idx].ROB_entry;
      rs_data.branch_type    = entries[sel_idx].branch_type;
      rs_data.rs1            = rs1_vec[sel_idx];
      rs_data.rs2            = rs2_vec[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pick_idx   <= '0;
      last_pick_valid <= 1'b0;
    end else begin
      last_pick_idx   <= sel_idx;
      last_pick_valid <= rs_data.valid_operands && !flush;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(dispatch_fire) - OCC_W'(consume_fire);
    end
  end

endmodule
